// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader: FSM state encoding,
// instruction/address widths and the word-assembly helper.
package instr_loader_pkg;

  localparam int INSTR_W         = 20;
  localparam int ADDR_W          = 8;
  localparam int BYTES_PER_INSTR = 3;

  typedef enum logic [3:0] {
    IDLE,
    LEN,
    B0,
    B1,
    B2,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  // Little-endian: b0 is the low byte, and only the low nibble of b2 is used.
  function automatic logic [INSTR_W-1:0] pack_instr(input logic [7:0] b0,
                                                     input logic [7:0] b1,
                                                     input logic [3:0] b2_lo);
    return {b2_lo, b1, b0};
  endfunction

endpackage

// File: rtl/instr_loader.sv
// Streams a length-prefixed, XOR-checksummed program into instruction memory
// and holds the core in reset until a load completes cleanly.
//
// state | meaning
// IDLE  | waiting for start after reset, core held
// LEN   | accepting instruction-count byte (0 means 256)
// B0    | accepting instruction bits [7:0]
// B1    | accepting instruction bits [15:8]
// B2    | accepting instruction bits [19:16]; upper nibble must be zero
// WRITE | one-cycle instruction-memory write strobe
// CSUM  | accepting checksum byte
// DONE  | load good, core released
// ERR   | format or checksum fault, core held
module instr_loader
  import instr_loader_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               im_write_en,
  output logic [ADDR_W-1:0]  im_write_addr,
  output logic [INSTR_W-1:0] im_write_data,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [8:0]        written_q;
  logic [8:0]        target_q;
  logic [7:0]        csum_q;
  logic [7:0]        b0_q;
  logic [7:0]        b1_q;
  logic              xfer;

  assign xfer = byte_valid && byte_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    byte_ready  = 1'b0;
    im_write_en = 1'b0;
    cpu_hold    = 1'b1;
    done        = 1'b0;
    error       = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LEN;
      LEN: begin
        byte_ready = 1'b1;
        if (xfer) state_d = B0;
      end
      B0: begin
        byte_ready = 1'b1;
        if (xfer) state_d = B1;
      end
      B1: begin
        byte_ready = 1'b1;
        if (xfer) state_d = B2;
      end
      B2: begin
        byte_ready = 1'b1;
        if (xfer) state_d = (byte_data[7:4] != 4'h0) ? ERR : WRITE;
      end
      WRITE: begin
        im_write_en = 1'b1;
        state_d     = (written_q + 9'd1 == target_q) ? CSUM : B0;
      end
      CSUM: begin
        byte_ready = 1'b1;
        if (xfer) state_d = (byte_data == csum_q) ? DONE : ERR;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_d = LEN;
      end
      ERR: begin
        error = 1'b1;
        if (start) state_d = LEN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q        <= '0;
      written_q     <= '0;
      target_q      <= '0;
      csum_q        <= '0;
      b0_q          <= '0;
      b1_q          <= '0;
      im_write_addr <= '0;
      im_write_data <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            addr_q    <= '0;
            written_q <= '0;
            target_q  <= '0;
            csum_q    <= '0;
          end
        end
        LEN: begin
          if (xfer) begin
            // A zero count byte encodes a full 256-instruction image.
            target_q <= {(byte_data == 8'd0), byte_data};
            csum_q   <= csum_q ^ byte_data;
          end
        end
        B0: begin
          if (xfer) begin
            b0_q   <= byte_data;
            csum_q <= csum_q ^ byte_data;
          end
        end
        B1: begin
          if (xfer) begin
            b1_q   <= byte_data;
            csum_q <= csum_q ^ byte_data;
          end
        end
        B2: begin
          if (xfer) begin
            csum_q <= csum_q ^ byte_data;
            if (byte_data[7:4] == 4'h0) begin
              im_write_addr <= addr_q;
              im_write_data <= pack_instr(b0_q, b1_q, byte_data[3:0]);
            end
          end
        end
        WRITE: begin
          addr_q    <= addr_q + 8'd1;
          written_q <= written_q + 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: short loads, bad checksum/format, a full
// 256-instruction image with stalls, and reset mid-load.
module tb_instr_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_write_en;
  logic [7:0]  im_write_addr;
  logic [19:0] im_write_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [27:0] wq[$];
  logic [19:0] exp_d[256];

  instr_loader dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .im_write_en   (im_write_en),
    .im_write_addr (im_write_addr),
    .im_write_data (im_write_data),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .error         (error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (im_write_en) wq.push_back({im_write_addr, im_write_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clock);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("ready_wait", {31'd0, byte_ready}, 32'd1);
    @(negedge clock);
    byte_valid = 1'b0;
    byte_data  = 8'hEE;
  endtask

  task automatic send_seq(input logic [7:0] s[$], input int gap);
    foreach (s[i]) send_byte(s[i], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] csum;
    logic [7:0] b0, b1, b2;

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(negedge clock);
    check("rst_hold",  {31'd0, cpu_hold},    32'd1);
    check("rst_done",  {31'd0, done},        32'd0);
    check("rst_error", {31'd0, error},       32'd0);
    check("rst_ready", {31'd0, byte_ready},  32'd0);
    check("rst_wen",   {31'd0, im_write_en}, 32'd0);
    check("rst_waddr", {24'd0, im_write_addr}, 32'd0);
    check("rst_wdata", {12'd0, im_write_data}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_hold",  {31'd0, cpu_hold},   32'd1);
    check("idle_ready", {31'd0, byte_ready}, 32'd0);

    // Two-instruction load; XOR of 02,34,12,05,78,56,0A is 05. start held mid-load must be ignored.
    pulse_start();
    check("len_ready", {31'd0, byte_ready}, 32'd1);
    send_byte(8'h02, 0);
    start = 1'b1;
    s = '{8'h34, 8'h12, 8'h05, 8'h78, 8'h56, 8'h0A};
    send_seq(s, 1);
    start = 1'b0;
    send_byte(8'h05, 2);
    check("a_done",   {31'd0, done},     32'd1);
    check("a_hold",   {31'd0, cpu_hold}, 32'd0);
    check("a_error",  {31'd0, error},    32'd0);
    check("a_nwr",    wq.size(),         32'd2);
    if (wq.size() == 2) begin
      check("a_wr0", {4'd0, wq[0]}, {4'd0, 8'h00, 20'h51234});
      check("a_wr1", {4'd0, wq[1]}, {4'd0, 8'h01, 20'hA5678});
    end
    repeat (4) @(negedge clock);
    check("a_done_hold", {31'd0, done}, 32'd1);

    // Bad checksum 00.
    wq.delete();
    pulse_start();
    check("b_done_clr", {31'd0, done}, 32'd0);
    s = '{8'h02, 8'h34, 8'h12, 8'h05, 8'h78, 8'h56, 8'h0A, 8'h00};
    send_seq(s, 0);
    check("b_nwr",   wq.size(),          32'd2);
    check("b_error", {31'd0, error},     32'd1);
    check("b_done",  {31'd0, done},      32'd0);
    check("b_hold",  {31'd0, cpu_hold},  32'd1);
    if (wq.size() == 2) check("b_wr0", {4'd0, wq[0]}, {4'd0, 8'h00, 20'h51234});

    // Bad checksum 15.
    wq.delete();
    pulse_start();
    check("c_err_clr", {31'd0, error}, 32'd0);
    s = '{8'h02, 8'h34, 8'h12, 8'h05, 8'h78, 8'h56, 8'h0A, 8'h15};
    send_seq(s, 1);
    check("c_error", {31'd0, error}, 32'd1);
    check("c_nwr",   wq.size(),      32'd2);

    // Format fault: nonzero upper nibble in the third byte, no write.
    wq.delete();
    pulse_start();
    s = '{8'h01, 8'h11, 8'h22, 8'hF3};
    send_seq(s, 0);
    check("f_nwr",   wq.size(),      32'd0);
    check("f_error", {31'd0, error}, 32'd1);
    check("f_wdata_hold", {12'd0, im_write_data}, {12'd0, 20'hA5678});
    check("f_waddr_hold", {24'd0, im_write_addr}, 32'd1);

    // Full 256-instruction image with random stalls.
    wq.delete();
    pulse_start();
    csum = 8'h00;
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      b0 = i[7:0];
      b1 = i[7:0] ^ 8'hA5;
      b2 = {4'h0, i[7:4] ^ 4'h9};
      exp_d[i] = {b2[3:0], b1, b0};
      csum = csum ^ b0 ^ b1 ^ b2;
      send_byte(b0, $urandom_range(0, 2));
      send_byte(b1, $urandom_range(0, 2));
      send_byte(b2, $urandom_range(0, 2));
    end
    send_byte(csum, 3);
    check("d_nwr",  wq.size(),        32'd256);
    check("d_done", {31'd0, done},    32'd1);
    check("d_hold", {31'd0, cpu_hold}, 32'd0);
    if (wq.size() == 256) begin
      for (int i = 0; i < 256; i++)
        check($sformatf("d_wr%0d", i), {4'd0, wq[i]}, {4'd0, i[7:0], exp_d[i]});
    end
    check("d_last_addr", {24'd0, im_write_addr}, 32'hFF);

    // Reset after the B1 byte: immediate idle, no write, then a clean reload.
    wq.delete();
    pulse_start();
    s = '{8'h02, 8'h34, 8'h12};
    send_seq(s, 0);
    reset = 1'b1;
    #1;
    check("e_hold",  {31'd0, cpu_hold},    32'd1);
    check("e_ready", {31'd0, byte_ready},  32'd0);
    check("e_wen",   {31'd0, im_write_en}, 32'd0);
    check("e_done",  {31'd0, done},        32'd0);
    check("e_waddr", {24'd0, im_write_addr}, 32'd0);
    check("e_wdata", {12'd0, im_write_data}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("e_nwr",   wq.size(), 32'd0);
    check("e_idle_ready", {31'd0, byte_ready}, 32'd0);
    pulse_start();
    s = '{8'h02, 8'h34, 8'h12, 8'h05, 8'h78, 8'h56, 8'h0A, 8'h05};
    send_seq(s, 1);
    check("e_done2", {31'd0, done}, 32'd1);
    check("e_nwr2",  wq.size(),     32'd2);
    if (wq.size() == 2) begin
      check("e_wr0", {4'd0, wq[0]}, {4'd0, 8'h00, 20'h51234});
      check("e_wr1", {4'd0, wq[1]}, {4'd0, 8'h01, 20'hA5678});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
